sub_div_seq: RTL and testbench

//  Sequencer that runs unsigned restoring division on the team's shared

---
 rtl/sub_div_seq.sv | 105 ++++++++++
 tb/tb_sub_div_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sub_div_seq.sv
// Restoring unsigned divider sequencer driving an external combinational subtractor,
// one trial subtraction per clock, behind a start/busy/done handshake.
module sub_div_seq #(
    parameter int              WIDTH  = 4,
    parameter logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    input  logic [WIDTH-1:0] sub_s,
    input  logic             sub_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] d_reg, q_reg, r_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p, q_next, r_next;

    // Partial remainder shifted left with the next dividend bit from Q's MSB.
    assign p      = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign r_next = sub_cout ? sub_s : p;
    assign q_next = {q_reg[WIDTH-2:0], sub_cout};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        sub_a = '0;
        sub_b = '0;
        if (state == ITER) begin
            sub_a = p;
            sub_b = d_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (divisor == '0) ? DONE : ITER;
            ITER: if (cnt == '0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_reg     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d_reg <= divisor;
                        q_reg <= dividend;
                        r_reg <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        // Divide-by-zero skips iteration; results land as DONE is entered.
                        if (divisor == '0) begin
                            quotient  <= ZERO_Q;
                            remainder <= dividend;
                            dbz       <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    if (cnt == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        dbz       <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_div_seq.sv
// Bench for sub_div_seq: behavioural subtractor, directed and random divisions,
// scoreboard queue of expected {dbz, quotient, remainder} checked on each done.
module tb_sub_div_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, dbz;
    logic [W-1:0] quotient, remainder;
    logic [W-1:0] sub_a, sub_b, sub_s;
    logic         sub_cout;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*W:0] exp_q[$];
    logic [2*W:0] mon_e;

    sub_div_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .dbz(dbz),
        .sub_a(sub_a), .sub_b(sub_b), .sub_s(sub_s), .sub_cout(sub_cout)
    );

    // Shared subtractor stand-in
    assign sub_s    = sub_a - sub_b;
    assign sub_cout = (sub_a >= sub_b);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [2*W:0] ref_result(input int a, input int b);
        if (b == 0) return {1'b1, W'((1 << W) - 1), W'(a)};
        return {1'b0, W'(a / b), W'(a % b)};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("quotient",  quotient,  mon_e[2*W-1:W]);
                check("remainder", remainder, mon_e[W-1:0]);
                check("dbz",       dbz,       mon_e[2*W]);
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic run_div(input int a, input int b, input bit intrude);
        int n = 0;
        int busy_n = 0;
        bit seen = 0;
        int exp_lat;
        wait_idle();
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        exp_q.push_back(ref_result(a, b));
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                seen = 1;
                n = k;
                if (b == 0) begin
                    check("dbz_sub_a", sub_a, 0);
                    check("dbz_sub_b", sub_b, 0);
                end
                start = 1'b0;
            end else begin
                if (b != 0) check("iter_sub_b", sub_b, b);
                if (intrude && k == 2) begin
                    start    = 1'b1;
                    dividend = W'($urandom);
                    divisor  = W'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end
        exp_lat = (b == 0) ? 1 : W + 1;
        check("latency", n, exp_lat);
        check("busy_width", busy_n, exp_lat);
    endtask

    task automatic reset_mid_div();
        wait_idle();
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", dbz, 0);
        check("rst_sub_a", sub_a, 0);
        check("rst_sub_b", sub_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_quotient", quotient, 0);
        check("init_remainder", remainder, 0);
        check("init_dbz", dbz, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_div(13, 3, 0);
        run_div(15, 1, 0);
        run_div(7, 9, 0);
        run_div(9, 0, 0);
        run_div(14, 15, 1);
        run_div(10, 0, 0);
        run_div(11, 4, 0);
        reset_mid_div();
        run_div(12, 5, 0);

        for (int a = 0; a < (1 << W); a++)
            for (int b = 0; b < (1 << W); b++)
                run_div(a, b, 0);

        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_div(int'($urandom_range(0, (1 << W) - 1)),
                    int'($urandom_range(0, (1 << W) - 1)),
                    bit'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
